// File: rtl/id_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_redirect_ctrl
// Purpose  : IF/ID pipeline register, RV32I branch/jump resolution in ID and
//            hazard detection, driving btaken/EXE_in/stall back to fetch.
// Revision : 1.0 - initial release
// ============================================================================
module id_redirect_ctrl #(
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] PC_in,
    input  logic [BW-1:0] Instruction_in,
    input  logic [BW-1:0] rs1_data,
    input  logic [BW-1:0] rs2_data,
    output logic          btaken,
    output logic [BW-1:0] EXE_in,
    output logic          stall,
    output logic [BW-1:0] ID_PC,
    output logic [BW-1:0] ID_Instruction,
    output logic          ID_valid
);

    localparam logic [6:0]    c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]    c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]    c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]    c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]    c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]    c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]    c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]    c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]    c_OP_OP     = 7'b0110011;
    localparam logic [BW-1:0] c_NOP       = 32'h00000013;

    // In-flight destination trackers for the EX and MEM stages
    logic [4:0] r_ex_rd;
    logic       r_ex_load;
    logic [4:0] r_mem_rd;

    // Field extraction from the ID instruction
    logic [6:0] w_opcode;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic [2:0] w_funct3;
    assign w_opcode = ID_Instruction[6:0];
    assign w_rd     = ID_Instruction[11:7];
    assign w_funct3 = ID_Instruction[14:12];
    assign w_rs1    = ID_Instruction[19:15];
    assign w_rs2    = ID_Instruction[24:20];

    logic w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic w_is_load, w_is_store, w_is_opimm, w_is_op;
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_opimm  = (w_opcode == c_OP_OPIMM);
    assign w_is_op     = (w_opcode == c_OP_OP);

    logic w_writes, w_uses_rs1, w_uses_rs2;
    assign w_writes   = (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr |
                         w_is_load | w_is_opimm | w_is_op) && (w_rd != 5'd0);
    assign w_uses_rs1 = w_is_jalr | w_is_branch | w_is_load | w_is_store |
                        w_is_opimm | w_is_op;
    assign w_uses_rs2 = w_is_branch | w_is_store | w_is_op;

    // x0 is excluded so a hard-wired zero never creates a dependency
    logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
    assign w_rs1_ex  = w_uses_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_ex_rd);
    assign w_rs2_ex  = w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_ex_rd);
    assign w_rs1_mem = w_uses_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_mem_rd);
    assign w_rs2_mem = w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_mem_rd);

    // Branch/JALR resolve in ID with no forwarding, so they wait out EX and MEM
    logic w_resolves, w_ctrl_hz, w_load_use, w_go;
    assign w_resolves = w_is_branch | w_is_jalr;
    assign w_ctrl_hz  = w_resolves && (w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem);
    assign w_load_use = !w_resolves && r_ex_load && (w_rs1_ex | w_rs2_ex);
    assign stall      = ID_valid && (w_ctrl_hz || w_load_use);
    assign w_go       = ID_valid && !stall;

    // Sign-extended immediates
    logic [BW-1:0] w_imm_i, w_imm_b, w_imm_j;
    assign w_imm_i = {{20{ID_Instruction[31]}}, ID_Instruction[31:20]};
    assign w_imm_b = {{19{ID_Instruction[31]}}, ID_Instruction[31], ID_Instruction[7],
                      ID_Instruction[30:25], ID_Instruction[11:8], 1'b0};
    assign w_imm_j = {{11{ID_Instruction[31]}}, ID_Instruction[31], ID_Instruction[19:12],
                      ID_Instruction[20], ID_Instruction[30:21], 1'b0};

    // Branch condition evaluation; funct3 010/011 are never taken
    logic w_cond;
    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = (rs1_data == rs2_data);
            3'b001:  w_cond = (rs1_data != rs2_data);
            3'b100:  w_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  w_cond = (rs1_data <  rs2_data);
            3'b111:  w_cond = (rs1_data >= rs2_data);
            default: w_cond = 1'b0;
        endcase
    end

    // Redirect target selection
    logic [BW-1:0] w_target;
    always_comb begin
        w_target = '0;
        if (w_is_jal)
            w_target = ID_PC + w_imm_j;
        else if (w_is_jalr)
            w_target = (rs1_data + w_imm_i) & {{(BW-1){1'b1}}, 1'b0};
        else
            w_target = ID_PC + w_imm_b;
    end

    logic w_take;
    assign w_take = w_go && (w_is_jal || w_is_jalr || (w_is_branch && w_cond));
    assign btaken = w_take;
    assign EXE_in = w_take ? w_target : '0;

    // Track destinations of instructions that left ID; bubbles carry rd=0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd   <= 5'd0;
            r_ex_load <= 1'b0;
            r_mem_rd  <= 5'd0;
        end else begin
            r_mem_rd  <= r_ex_rd;
            r_ex_rd   <= (w_go && w_writes) ? w_rd : 5'd0;
            r_ex_load <= w_go && w_writes && w_is_load;
        end
    end

    // IF/ID register: squash on redirect, hold on stall, otherwise advance
    always_ff @(posedge clk) begin
        if (rst) begin
            ID_PC          <= '0;
            ID_Instruction <= c_NOP;
            ID_valid       <= 1'b0;
        end else if (btaken) begin
            ID_Instruction <= c_NOP;
            ID_valid       <= 1'b0;
        end else if (!stall) begin
            ID_PC          <= PC_in;
            ID_Instruction <= Instruction_in;
            ID_valid       <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_redirect_ctrl
// Purpose  : Directed, table-driven self-checking bench for id_redirect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_redirect_ctrl;

    localparam logic [31:0] c_NOP   = 32'h00000013;
    localparam logic [31:0] c_ADDI1 = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] c_JAL16 = 32'h0100006F; // jal x0,+16
    localparam logic [31:0] c_BEQ   = 32'hFE208CE3; // beq x1,x2,-8
    localparam logic [31:0] c_LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] c_ADD   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] c_ADDI3 = 32'h00700193; // addi x3,x0,7
    localparam logic [31:0] c_BNE   = 32'h00019463; // bne x3,x0,+8
    localparam logic [31:0] c_JALR  = 32'h00510067; // jalr x0,5(x2)
    localparam logic [31:0] c_BLT   = 32'h0020C863; // blt x1,x2,+16
    localparam logic [31:0] c_BLTU  = 32'h0020E863; // bltu x1,x2,+16
    localparam logic [31:0] c_B010  = 32'h0020A863; // branch funct3=010

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in, Instruction_in, rs1_data, rs2_data;
    logic        btaken, stall, ID_valid;
    logic [31:0] EXE_in, ID_PC, ID_Instruction;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_redirect_ctrl #(.BW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_in          (PC_in),
        .Instruction_in (Instruction_in),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .btaken         (btaken),
        .EXE_in         (EXE_in),
        .stall          (stall),
        .ID_PC          (ID_PC),
        .ID_Instruction (ID_Instruction),
        .ID_valid       (ID_valid)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc, ins, r1, r2;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc, e_ins;
        logic        e_stall, e_bt;
        logic [31:0] e_exe;
        logic [4:0]  e_exrd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [31:0] pc, ins, r1, r2,
                       input logic ev, cp, input logic [31:0] epc, eins,
                       input logic est, ebt, input logic [31:0] eexe,
                       input logic [4:0] exrd);
        vec_t v;
        v.rst = r; v.pc = pc; v.ins = ins; v.r1 = r1; v.r2 = r2;
        v.e_valid = ev; v.chk_pc = cp; v.e_pc = epc; v.e_ins = eins;
        v.e_stall = est; v.e_bt = ebt; v.e_exe = eexe; v.e_exrd = exrd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, ins, r1, r2);
        rst = r; PC_in = pc; Instruction_in = ins; rs1_data = r1; rs2_data = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst pc      ins      r1           r2   | val cp  ID_PC   ID_Ins   stl bt  EXE    ex_rd
        add(0, 0,      c_ADDI1, 0,           0,     0, 1, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 4,      c_ADDI1, 0,           0,     1, 1, 0,      c_ADDI1, 0, 0, 0,     0);
        add(0, 8,      c_JAL16, 0,           0,     1, 1, 4,      c_ADDI1, 0, 0, 0,     1);
        add(0, 12,     c_ADDI1, 0,           0,     1, 1, 8,      c_JAL16, 0, 1, 24,    1);
        add(0, 24,     c_NOP,   0,           0,     0, 0, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 28,     c_NOP,   0,           0,     1, 1, 24,     c_NOP,   0, 0, 0,     0);
        add(0, 32,     c_BEQ,   0,           0,     1, 1, 28,     c_NOP,   0, 0, 0,     0);
        add(0, 36,     c_NOP,   5,           5,     1, 1, 32,     c_BEQ,   0, 1, 24,    0);
        add(0, 24,     c_NOP,   0,           0,     0, 0, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 28,     c_NOP,   0,           0,     1, 1, 24,     c_NOP,   0, 0, 0,     0);
        add(0, 32,     c_BEQ,   0,           0,     1, 1, 28,     c_NOP,   0, 0, 0,     0);
        add(0, 36,     c_ADDI1, 5,           6,     1, 1, 32,     c_BEQ,   0, 0, 0,     0);
        add(0, 40,     c_LW,    0,           0,     1, 1, 36,     c_ADDI1, 0, 0, 0,     0);
        add(0, 44,     c_ADD,   0,           0,     1, 1, 40,     c_LW,    0, 0, 0,     1);
        add(0, 48,     c_NOP,   0,           0,     1, 1, 44,     c_ADD,   1, 0, 0,     5);
        add(0, 48,     c_NOP,   0,           0,     1, 1, 44,     c_ADD,   0, 0, 0,     0);
        add(0, 52,     c_ADDI3, 0,           0,     1, 1, 48,     c_NOP,   0, 0, 0,     6);
        add(0, 56,     c_BNE,   0,           0,     1, 1, 52,     c_ADDI3, 0, 0, 0,     0);
        add(0, 60,     c_NOP,   7,           0,     1, 1, 56,     c_BNE,   1, 0, 0,     3);
        add(0, 60,     c_NOP,   7,           0,     1, 1, 56,     c_BNE,   1, 0, 0,     0);
        add(0, 60,     c_NOP,   7,           0,     1, 1, 56,     c_BNE,   0, 1, 64,    0);
        add(0, 64,     c_NOP,   0,           0,     0, 0, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 68,     c_NOP,   0,           0,     1, 1, 64,     c_NOP,   0, 0, 0,     0);
        // reset arrives during the second control-hazard stall cycle
        add(0, 72,     c_ADDI3, 0,           0,     1, 1, 68,     c_NOP,   0, 0, 0,     0);
        add(0, 76,     c_BNE,   0,           0,     1, 1, 72,     c_ADDI3, 0, 0, 0,     0);
        add(0, 80,     c_NOP,   7,           0,     1, 1, 76,     c_BNE,   1, 0, 0,     3);
        add(1, 80,     c_NOP,   7,           0,     1, 1, 76,     c_BNE,   1, 0, 0,     0);
        add(0, 0,      c_ADDI1, 0,           0,     0, 1, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 4,      c_NOP,   0,           0,     1, 1, 0,      c_ADDI1, 0, 0, 0,     0);
        // JALR clears bit 0, signed vs unsigned compares, reserved funct3
        add(0, 8,      c_JALR,  0,           0,     1, 1, 4,      c_NOP,   0, 0, 0,     1);
        add(0, 12,     c_NOP,   32'h100,     0,     1, 1, 8,      c_JALR,  0, 1, 32'h104, 0);
        add(0, 32'h104, c_NOP,  0,           0,     0, 0, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 32'h108, c_BLT,  0,           0,     1, 1, 32'h104, c_NOP,  0, 0, 0,     0);
        add(0, 32'h10C, c_BLTU, 32'hFFFFFFFF, 1,    1, 1, 32'h108, c_BLT,  0, 1, 32'h118, 0);
        add(0, 32'h118, c_BLTU, 0,           0,     0, 0, 0,      c_NOP,   0, 0, 0,     0);
        add(0, 32'h11C, c_B010, 32'hFFFFFFFF, 1,    1, 1, 32'h118, c_BLTU, 0, 0, 0,     0);
        add(0, 32'h120, c_NOP,  0,           1,     1, 1, 32'h11C, c_B010, 0, 0, 0,     0);
        add(0, 32'h124, c_NOP,  0,           0,     1, 1, 32'h120, c_NOP,  0, 0, 0,     0);

        drive(1, 0, c_NOP, 0, 0);
        step();
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].pc, tbl[i].ins, tbl[i].r1, tbl[i].r2);
            @(negedge clk);
            chk("ID_valid", i, {31'd0, ID_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].chk_pc)
                chk("ID_PC", i, ID_PC, tbl[i].e_pc);
            chk("ID_Instruction", i, ID_Instruction, tbl[i].e_ins);
            chk("stall", i, {31'd0, stall}, {31'd0, tbl[i].e_stall});
            chk("btaken", i, {31'd0, btaken}, {31'd0, tbl[i].e_bt});
            chk("EXE_in", i, EXE_in, tbl[i].e_exe);
            chk("ex_rd", i, {27'd0, dut.r_ex_rd}, {27'd0, tbl[i].e_exrd});
            step();
        end

        // Reset asserted on a redirect cycle wins over the squash
        drive(0, 32'h128, c_JAL16, 0, 0);
        step();
        drive(1, 32'h12C, c_NOP, 0, 0);
        @(negedge clk);
        chk("redir_bt", 100, {31'd0, btaken}, 32'd1);
        chk("redir_exe", 100, EXE_in, 32'h138);
        step();
        drive(0, 32'h200, c_ADDI1, 0, 0);
        @(negedge clk);
        chk("rstredir_valid", 101, {31'd0, ID_valid}, 32'd0);
        chk("rstredir_pc", 101, ID_PC, 32'd0);
        chk("rstredir_ins", 101, ID_Instruction, c_NOP);
        chk("rstredir_bt", 101, {31'd0, btaken}, 32'd0);
        chk("rstredir_stall", 101, {31'd0, stall}, 32'd0);
        chk("rstredir_exe", 101, EXE_in, 32'd0);
        step();
        drive(0, 32'h204, c_NOP, 0, 0);
        @(negedge clk);
        chk("post_valid", 102, {31'd0, ID_valid}, 32'd1);
        chk("post_pc", 102, ID_PC, 32'h200);
        chk("post_ins", 102, ID_Instruction, c_ADDI1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_redirect_ctrl.md
# id_redirect_ctrl

Decode-side partner of the instruction fetch stage: holds the IF/ID pipeline register, resolves RV32I branches and jumps in ID, and detects hazards. It drives the fetch stage's `btaken`, `EXE_in` and `stall` inputs from the `PC_out` and `Instruction_data` values that fetch produces. Branch penalty is one squashed instruction; hazard stalls last one or two cycles.

## Interface
- `BW`, 32, datapath and address width (RV32I encodings, fixed at 32)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `PC_in`  in  BW  fetch `PC_out` for the instruction being presented
- `Instruction_in`  in  BW  fetch `Instruction_data`
- `rs1_data`  in  BW  register-file read of `ID_Instruction[19:15]` (write-through regfile)
- `rs2_data`  in  BW  register-file read of `ID_Instruction[24:20]`
- `btaken`  out  1  redirect fetch to `EXE_in` at the next edge
- `EXE_in`  out  BW  redirect target; 0 when `btaken`=0
- `stall`  out  1  fetch holds its PC at the next edge
- `ID_PC`  out  BW  registered PC of the ID instruction
- `ID_Instruction`  out  BW  registered ID instruction
- `ID_valid`  out  1  ID holds a real instruction

## Operation
- Opcode classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other opcode is a no-op: no write, no reads, no redirect.
- A write is a LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP instruction with rd≠0.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used by BRANCH, STORE and OP. Register x0 never matches.
- In-flight tracker registers: `ex_rd`, `ex_load`, `mem_rd`.
  - Each edge: `mem_rd`←`ex_rd`.
  - `ex_rd`/`ex_load` take the ID instruction's rd and load flag when `ID_valid` && !`stall` && the instruction writes. Otherwise they take 0.
- Hazards, evaluated only when `ID_valid`=1:
  - Control hazard: ID is BRANCH or JALR, and a used rs matches `ex_rd` or `mem_rd`.
  - Load-use: ID is any other instruction, `ex_load`=1, and a used rs matches `ex_rd`.
  - `stall` = control hazard OR load-use.
- Resolve, gated by `ID_valid` && !`stall`:
  - JAL is always taken, target `ID_PC`+immJ.
  - JALR is always taken, target (`rs1_data`+immI) & ~1.
  - BRANCH funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU; target `ID_PC`+immB.
  - BRANCH funct3 010/011 is never taken.
  - Immediates are sign-extended. Additions are mod 2^32, with wrap-around allowed.
- IF/ID register update, in priority order:
  1. `rst`: `ID_PC`=0, `ID_Instruction`=32'h00000013, `ID_valid`=0.
  2. `btaken`: load the NOP, `ID_valid`=0. This squashes the wrong-path fetch.
  3. `stall`: hold all three.
  4. Otherwise: load `PC_in`/`Instruction_in`, `ID_valid`=1.
- `btaken` and `stall` are never both 1.

## Timing
- `btaken`, `EXE_in` and `stall` are combinational from registered state plus `rs1_data`/`rs2_data`. Fetch samples them at the same edge.
- Redirect: `btaken`=1 in cycle N. Fetch PC = target after edge N. ID holds the bubble in N+1 and the target instruction in N+2.
- Load-use stall is exactly 1 cycle.
- Control-hazard stall is 1 cycle if the match is only in `mem_rd`, 2 cycles if the match is in `ex_rd`.
- Reset values: `btaken`=0, `EXE_in`=0, `stall`=0, `ID_valid`=0, `ID_PC`=0, `ID_Instruction`=32'h00000013, tracker all 0.
- Reset asserted mid-stall or on a redirect cycle wins. Next cycle has no stall and no redirect.

## Test plan
- Reset, then sequential stream PC 0,4,8 of ADDI x1,x0,1 (32'h00100093): `ID_valid`=1 one cycle after each present, `stall`=0, `btaken`=0 throughout.
- JAL x0,+16 (32'h0100006F) at PC 8 -> `btaken`=1, `EXE_in`=24 for one cycle. Next cycle `ID_Instruction`=32'h00000013 and `ID_valid`=0.
- BEQ x1,x2,-8 at PC 32: with `rs1_data`=`rs2_data`=5 -> `EXE_in`=24, `btaken`=1. With `rs2_data`=6 -> `btaken`=0, and the PC 36 instruction enters ID next cycle.
- LW x5,0(x1) followed by ADD x6,x5,x7 -> `stall`=1 for exactly 1 cycle, `ID_PC` held, `ex_rd`=0 during the bubble, then ADD issues.
- ADDI x3,x0,7 followed by BNE x3,x0,+8 -> `stall`=1 for 2 cycles, then `btaken`=1 with `EXE_in`=BNE PC+8.
- Assert `rst` during the second stall cycle -> after the edge, all outputs are at reset values and the ID holds the NOP.
